// File: rtl/axil_arbiter_2x1.sv
// Two-master to one-slave AXI4-Lite arbiter. The write and read paths each
// have their own round-robin arbiter and allow one transaction in flight.
// Once a path holds a grant, its channels pass through combinationally.
//
// state  | meaning
// W_IDLE | no write grant held; pick a winner among pending AW requests
// W_XFER | forward AW and W from the granted master until both handshake
// W_RESP | forward B to the granted master until it is accepted
// R_IDLE | no read grant held; pick a winner among pending AR requests
// R_ADDR | forward AR from the granted master until it handshakes
// R_RESP | forward R to the granted master until it is accepted
module axil_arbiter_2x1 #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] s0_awaddr,
   input  logic [2:0]            s0_awprot,
   input  logic                  s0_awvalid,
   output logic                  s0_awready,
   input  logic [DATA_WIDTH-1:0] s0_wdata,
   input  logic [STRB_WIDTH-1:0] s0_wstrb,
   input  logic                  s0_wvalid,
   output logic                  s0_wready,
   output logic [1:0]            s0_bresp,
   output logic                  s0_bvalid,
   input  logic                  s0_bready,
   input  logic [ADDR_WIDTH-1:0] s0_araddr,
   input  logic [2:0]            s0_arprot,
   input  logic                  s0_arvalid,
   output logic                  s0_arready,
   output logic [DATA_WIDTH-1:0] s0_rdata,
   output logic [1:0]            s0_rresp,
   output logic                  s0_rvalid,
   input  logic                  s0_rready,
   input  logic [ADDR_WIDTH-1:0] s1_awaddr,
   input  logic [2:0]            s1_awprot,
   input  logic                  s1_awvalid,
   output logic                  s1_awready,
   input  logic [DATA_WIDTH-1:0] s1_wdata,
   input  logic [STRB_WIDTH-1:0] s1_wstrb,
   input  logic                  s1_wvalid,
   output logic                  s1_wready,
   output logic [1:0]            s1_bresp,
   output logic                  s1_bvalid,
   input  logic                  s1_bready,
   input  logic [ADDR_WIDTH-1:0] s1_araddr,
   input  logic [2:0]            s1_arprot,
   input  logic                  s1_arvalid,
   output logic                  s1_arready,
   output logic [DATA_WIDTH-1:0] s1_rdata,
   output logic [1:0]            s1_rresp,
   output logic                  s1_rvalid,
   input  logic                  s1_rready,
   output logic [ADDR_WIDTH-1:0] m_awaddr,
   output logic [2:0]            m_awprot,
   output logic                  m_awvalid,
   input  logic                  m_awready,
   output logic [DATA_WIDTH-1:0] m_wdata,
   output logic [STRB_WIDTH-1:0] m_wstrb,
   output logic                  m_wvalid,
   input  logic                  m_wready,
   input  logic [1:0]            m_bresp,
   input  logic                  m_bvalid,
   output logic                  m_bready,
   output logic [ADDR_WIDTH-1:0] m_araddr,
   output logic [2:0]            m_arprot,
   output logic                  m_arvalid,
   input  logic                  m_arready,
   input  logic [DATA_WIDTH-1:0] m_rdata,
   input  logic [1:0]            m_rresp,
   input  logic                  m_rvalid,
   output logic                  m_rready
);

   typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} rstate_t;

   wstate_t r_wstate;
   logic    r_wgrant;
   logic    r_last_wgrant;
   logic    r_aw_done;
   logic    r_w_done;
   rstate_t r_rstate;
   logic    r_rgrant;
   logic    r_last_rgrant;

   logic w_wpick, w_rpick;
   logic w_xfer, w_wresp, w_raddr, w_rresp;
   logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
   logic w_sel_awvalid, w_sel_wvalid, w_sel_arvalid;

   // On a tie the master that did not win last time gets the path
   assign w_wpick = (s0_awvalid & s1_awvalid) ? ~r_last_wgrant : s1_awvalid;
   assign w_rpick = (s0_arvalid & s1_arvalid) ? ~r_last_rgrant : s1_arvalid;

   assign w_xfer  = (r_wstate == W_XFER);
   assign w_wresp = (r_wstate == W_RESP);
   assign w_raddr = (r_rstate == R_ADDR);
   assign w_rresp = (r_rstate == R_RESP);

   assign w_sel_awvalid = r_wgrant ? s1_awvalid : s0_awvalid;
   assign w_sel_wvalid  = r_wgrant ? s1_wvalid  : s0_wvalid;
   assign w_sel_arvalid = r_rgrant ? s1_arvalid : s0_arvalid;

   assign m_awvalid = w_xfer & w_sel_awvalid & ~r_aw_done;
   assign m_awaddr  = w_xfer ? (r_wgrant ? s1_awaddr : s0_awaddr) : '0;
   assign m_awprot  = w_xfer ? (r_wgrant ? s1_awprot : s0_awprot) : '0;
   assign m_wvalid  = w_xfer & w_sel_wvalid & ~r_w_done;
   assign m_wdata   = w_xfer ? (r_wgrant ? s1_wdata : s0_wdata) : '0;
   assign m_wstrb   = w_xfer ? (r_wgrant ? s1_wstrb : s0_wstrb) : '0;
   assign m_bready  = w_wresp & (r_wgrant ? s1_bready : s0_bready);

   assign s0_awready = w_xfer & ~r_wgrant & m_awready & ~r_aw_done;
   assign s1_awready = w_xfer &  r_wgrant & m_awready & ~r_aw_done;
   assign s0_wready  = w_xfer & ~r_wgrant & m_wready & ~r_w_done;
   assign s1_wready  = w_xfer &  r_wgrant & m_wready & ~r_w_done;
   assign s0_bvalid  = w_wresp & ~r_wgrant & m_bvalid;
   assign s1_bvalid  = w_wresp &  r_wgrant & m_bvalid;
   assign s0_bresp   = (w_wresp & ~r_wgrant) ? m_bresp : 2'b00;
   assign s1_bresp   = (w_wresp &  r_wgrant) ? m_bresp : 2'b00;

   assign m_arvalid = w_raddr & w_sel_arvalid;
   assign m_araddr  = w_raddr ? (r_rgrant ? s1_araddr : s0_araddr) : '0;
   assign m_arprot  = w_raddr ? (r_rgrant ? s1_arprot : s0_arprot) : '0;
   assign m_rready  = w_rresp & (r_rgrant ? s1_rready : s0_rready);

   assign s0_arready = w_raddr & ~r_rgrant & m_arready;
   assign s1_arready = w_raddr &  r_rgrant & m_arready;
   assign s0_rvalid  = w_rresp & ~r_rgrant & m_rvalid;
   assign s1_rvalid  = w_rresp &  r_rgrant & m_rvalid;
   assign s0_rdata   = (w_rresp & ~r_rgrant) ? m_rdata : '0;
   assign s1_rdata   = (w_rresp &  r_rgrant) ? m_rdata : '0;
   assign s0_rresp   = (w_rresp & ~r_rgrant) ? m_rresp : 2'b00;
   assign s1_rresp   = (w_rresp &  r_rgrant) ? m_rresp : 2'b00;

   assign w_aw_hs = m_awvalid & m_awready;
   assign w_w_hs  = m_wvalid & m_wready;
   assign w_b_hs  = m_bvalid & m_bready;
   assign w_ar_hs = m_arvalid & m_arready;
   assign w_r_hs  = m_rvalid & m_rready;

   // Write path: arbitrate, collect AW and W handshakes in any order, then B
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wstate      <= W_IDLE;
         r_wgrant      <= 1'b0;
         r_last_wgrant <= 1'b1;
         r_aw_done     <= 1'b0;
         r_w_done      <= 1'b0;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (s0_awvalid | s1_awvalid) begin
                  r_wgrant <= w_wpick;
                  r_wstate <= W_XFER;
               end
            end
            W_XFER: begin
               if (w_aw_hs) r_aw_done <= 1'b1;
               if (w_w_hs)  r_w_done  <= 1'b1;
               if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) r_wstate <= W_RESP;
            end
            W_RESP: begin
               if (w_b_hs) begin
                  r_last_wgrant <= r_wgrant;
                  r_aw_done     <= 1'b0;
                  r_w_done      <= 1'b0;
                  r_wstate      <= W_IDLE;
               end
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   // Read path: arbitrate, forward AR until accepted, then R until accepted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rstate      <= R_IDLE;
         r_rgrant      <= 1'b0;
         r_last_rgrant <= 1'b1;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (s0_arvalid | s1_arvalid) begin
                  r_rgrant <= w_rpick;
                  r_rstate <= R_ADDR;
               end
            end
            R_ADDR: begin
               if (w_ar_hs) r_rstate <= R_RESP;
            end
            R_RESP: begin
               if (w_r_hs) begin
                  r_last_rgrant <= r_rgrant;
                  r_rstate      <= R_IDLE;
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_arbiter_2x1.sv
// Bench for axil_arbiter_2x1: directed scenarios plus randomized traffic from
// both masters on both paths. A transaction-level reference model predicts
// which master owns each path; a monitor compares the slave-side and
// master-side activity against the queued expectations.
module tb_axil_arbiter_2x1;

   localparam int TMO = 300;
   localparam logic [31:0] RKEY = 32'h5A5A_0F0F;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]       tb_awvalid, tb_wvalid, tb_bready, tb_arvalid, tb_rready;
   logic [1:0][31:0] tb_awaddr, tb_wdata, tb_araddr;
   logic [1:0][2:0]  tb_awprot, tb_arprot;
   logic [1:0][3:0]  tb_wstrb;
   logic [1:0]       d_awready, d_wready, d_bvalid, d_arready, d_rvalid;
   logic [1:0][1:0]  d_bresp, d_rresp;
   logic [1:0][31:0] d_rdata;

   logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
   logic [2:0]  m_awprot, m_arprot;
   logic [3:0]  m_wstrb;
   logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic        m_arvalid, m_arready, m_rvalid, m_rready;
   logic [1:0]  m_bresp, m_rresp;

   int  n_chk = 0;
   int  n_err = 0;
   bit  rnd;
   bit  mon_en;
   int  w_stall;

   axil_arbiter_2x1 dut (
      .clk(clk), .rst(rst),
      .s0_awaddr(tb_awaddr[0]), .s0_awprot(tb_awprot[0]), .s0_awvalid(tb_awvalid[0]), .s0_awready(d_awready[0]),
      .s0_wdata(tb_wdata[0]), .s0_wstrb(tb_wstrb[0]), .s0_wvalid(tb_wvalid[0]), .s0_wready(d_wready[0]),
      .s0_bresp(d_bresp[0]), .s0_bvalid(d_bvalid[0]), .s0_bready(tb_bready[0]),
      .s0_araddr(tb_araddr[0]), .s0_arprot(tb_arprot[0]), .s0_arvalid(tb_arvalid[0]), .s0_arready(d_arready[0]),
      .s0_rdata(d_rdata[0]), .s0_rresp(d_rresp[0]), .s0_rvalid(d_rvalid[0]), .s0_rready(tb_rready[0]),
      .s1_awaddr(tb_awaddr[1]), .s1_awprot(tb_awprot[1]), .s1_awvalid(tb_awvalid[1]), .s1_awready(d_awready[1]),
      .s1_wdata(tb_wdata[1]), .s1_wstrb(tb_wstrb[1]), .s1_wvalid(tb_wvalid[1]), .s1_wready(d_wready[1]),
      .s1_bresp(d_bresp[1]), .s1_bvalid(d_bvalid[1]), .s1_bready(tb_bready[1]),
      .s1_araddr(tb_araddr[1]), .s1_arprot(tb_arprot[1]), .s1_arvalid(tb_arvalid[1]), .s1_arready(d_arready[1]),
      .s1_rdata(d_rdata[1]), .s1_rresp(d_rresp[1]), .s1_rvalid(d_rvalid[1]), .s1_rready(tb_rready[1]),
      .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
   );

   function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h at t=%0t", nm, got, exp, $time);
      end
   endfunction

   function automatic void fail(input string nm);
      n_chk++;
      n_err++;
      $display("FAIL %s: handshake not seen within %0d cycles at t=%0t", nm, TMO, $time);
   endfunction

   // ---------------- reference model and monitor ----------------
   typedef struct {
      int m; logic [31:0] a; logic [2:0] p; logic [31:0] d; logic [3:0] s; bit aw; bit w;
   } wtx_t;
   typedef struct {
      int m; logic [31:0] a; logic [2:0] p; bit ar;
   } rtx_t;

   wtx_t wq[$];
   rtx_t rq[$];

   initial begin
      bit wbusy, rbusy, wlat, rlat, ok, bhs, rhs;
      int wlast, rlast, g, wown, rown;
      wtx_t wt;
      rtx_t rt;
      forever begin
         @(negedge clk);
         if (!rst) begin
            wq.delete(); rq.delete();
            wbusy = 0; rbusy = 0; wlat = 0; rlat = 0; wlast = 1; rlast = 1;
         end else if (mon_en) begin
            if (wlat) begin
               chk("aw_grant_latency", {31'b0, m_awvalid}, 32'd1);
               chk("aw_addr_fwd", m_awaddr, wq[$].a);
               wlat = 0;
            end
            if (rlat) begin
               chk("ar_grant_latency", {31'b0, m_arvalid}, 32'd1);
               chk("ar_addr_fwd", m_araddr, rq[$].a);
               rlat = 0;
            end
            wown = (wq.size() > 0) ? wq[0].m : -1;
            rown = (rq.size() > 0) ? rq[0].m : -1;
            bhs = m_bvalid && m_bready;
            rhs = m_rvalid && m_rready;
            if (m_awvalid && m_awready) begin
               ok = wq.size() > 0 && !wq[0].aw;
               chk("aw_expected", {31'b0, ok}, 32'd1);
               if (ok) begin
                  chk("m_awaddr", m_awaddr, wq[0].a);
                  chk("m_awprot", {29'b0, m_awprot}, {29'b0, wq[0].p});
                  wq[0].aw = 1;
               end
            end
            if (m_wvalid && m_wready) begin
               ok = wq.size() > 0 && !wq[0].w;
               chk("w_expected", {31'b0, ok}, 32'd1);
               if (ok) begin
                  chk("m_wdata", m_wdata, wq[0].d);
                  chk("m_wstrb", {28'b0, m_wstrb}, {28'b0, wq[0].s});
                  wq[0].w = 1;
               end
            end
            if (m_arvalid && m_arready) begin
               ok = rq.size() > 0 && !rq[0].ar;
               chk("ar_expected", {31'b0, ok}, 32'd1);
               if (ok) begin
                  chk("m_araddr", m_araddr, rq[0].a);
                  chk("m_arprot", {29'b0, m_arprot}, {29'b0, rq[0].p});
                  rq[0].ar = 1;
               end
            end
            for (int n = 0; n < 2; n++) begin
               if (d_awready[n] || d_wready[n] || d_bvalid[n])
                  chk($sformatf("w_owner_s%0d", n), wown, n);
               if (d_arready[n] || d_rvalid[n])
                  chk($sformatf("r_owner_s%0d", n), rown, n);
               if (d_bvalid[n] && wown == n)
                  chk("b_after_aw_w", {31'b0, wq[0].aw && wq[0].w}, 32'd1);
               if (d_rvalid[n] && rown == n)
                  chk("r_after_ar", {31'b0, rq[0].ar}, 32'd1);
               if (d_bvalid[n] && tb_bready[n] && wown == n)
                  chk($sformatf("s%0d_bresp", n), {30'b0, d_bresp[n]}, {30'b0, wq[0].a[5:4]});
               if (d_rvalid[n] && tb_rready[n] && rown == n) begin
                  chk($sformatf("s%0d_rdata", n), d_rdata[n], rq[0].a ^ RKEY);
                  chk($sformatf("s%0d_rresp", n), {30'b0, d_rresp[n]}, {30'b0, rq[0].a[7:6]});
               end
            end
            if (bhs) begin
               if (wq.size() > 0) void'(wq.pop_front());
               wbusy = 0;
            end else if (!wbusy && tb_awvalid != 2'b00) begin
               g = (tb_awvalid == 2'b11) ? 1 - wlast : (tb_awvalid[0] ? 0 : 1);
               wt.m = g; wt.a = tb_awaddr[g]; wt.p = tb_awprot[g];
               wt.d = tb_wdata[g]; wt.s = tb_wstrb[g]; wt.aw = 0; wt.w = 0;
               wq.push_back(wt);
               wbusy = 1; wlast = g; wlat = 1;
            end
            if (rhs) begin
               if (rq.size() > 0) void'(rq.pop_front());
               rbusy = 0;
            end else if (!rbusy && tb_arvalid != 2'b00) begin
               g = (tb_arvalid == 2'b11) ? 1 - rlast : (tb_arvalid[0] ? 0 : 1);
               rt.m = g; rt.a = tb_araddr[g]; rt.p = tb_arprot[g]; rt.ar = 0;
               rq.push_back(rt);
               rbusy = 1; rlast = g; rlat = 1;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------- master and slave drivers ----------------
   task automatic m_write(input int n, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [2:0] p, input int aw_at, input int w_at);
      int t;
      bit awd, wd, bd;
      tb_awaddr[n] = a; tb_wdata[n] = d; tb_wstrb[n] = s; tb_awprot[n] = p;
      t = 0; awd = 0; wd = 0;
      while (!(awd && wd)) begin
         tb_awvalid[n] = !awd && (t >= aw_at);
         tb_wvalid[n]  = !wd && (t >= w_at);
         @(negedge clk);
         if (tb_awvalid[n] && d_awready[n]) awd = 1;
         if (tb_wvalid[n] && d_wready[n]) wd = 1;
         @(posedge clk); #1;
         t++;
         if (t > TMO) begin
            fail($sformatf("s%0d_aw_w_timeout", n));
            tb_awvalid[n] = 0; tb_wvalid[n] = 0;
            return;
         end
      end
      tb_awvalid[n] = 0; tb_wvalid[n] = 0;
      t = 0; bd = 0;
      while (!bd) begin
         tb_bready[n] = rnd ? 1'($urandom % 2) : 1'b1;
         @(negedge clk);
         if (d_bvalid[n] && tb_bready[n]) bd = 1;
         @(posedge clk); #1;
         t++;
         if (t > TMO) begin
            fail($sformatf("s%0d_b_timeout", n));
            break;
         end
      end
      tb_bready[n] = 0;
   endtask

   task automatic m_read(input int n, input logic [31:0] a, input logic [2:0] p, input int ar_at);
      int t;
      bit ard, rd;
      tb_araddr[n] = a; tb_arprot[n] = p;
      t = 0; ard = 0;
      while (!ard) begin
         tb_arvalid[n] = (t >= ar_at);
         @(negedge clk);
         if (tb_arvalid[n] && d_arready[n]) ard = 1;
         @(posedge clk); #1;
         t++;
         if (t > TMO) begin
            fail($sformatf("s%0d_ar_timeout", n));
            tb_arvalid[n] = 0;
            return;
         end
      end
      tb_arvalid[n] = 0;
      t = 0; rd = 0;
      while (!rd) begin
         tb_rready[n] = rnd ? 1'($urandom % 2) : 1'b1;
         @(negedge clk);
         if (d_rvalid[n] && tb_rready[n]) rd = 1;
         @(posedge clk); #1;
         t++;
         if (t > TMO) begin
            fail($sformatf("s%0d_r_timeout", n));
            break;
         end
      end
      tb_rready[n] = 0;
   endtask

   task automatic slave_w();
      bit ga, gw, bhs;
      logic [31:0] sa;
      ga = 0; gw = 0; sa = '0;
      forever begin
         @(negedge clk);
         bhs = m_bvalid && m_bready;
         if (!rst) begin
            ga = 0; gw = 0;
         end else begin
            if (m_awvalid && m_awready) begin ga = 1; sa = m_awaddr; end
            if (m_wvalid && m_wready) gw = 1;
            if (m_wvalid && w_stall > 0) w_stall--;
            if (bhs) begin ga = 0; gw = 0; end
         end
         @(posedge clk); #1;
         m_awready = rnd ? 1'($urandom % 2) : 1'b1;
         m_wready  = (w_stall > 0) ? 1'b0 : (rnd ? 1'($urandom % 2) : 1'b1);
         if (!rst || bhs) m_bvalid = 0;
         else if (ga && gw && !m_bvalid && (!rnd || $urandom % 3 == 0)) begin
            m_bvalid = 1; m_bresp = sa[5:4];
         end
      end
   endtask

   task automatic slave_r();
      bit ga, rhs;
      logic [31:0] sa;
      ga = 0; sa = '0;
      forever begin
         @(negedge clk);
         rhs = m_rvalid && m_rready;
         if (!rst) ga = 0;
         else begin
            if (m_arvalid && m_arready) begin ga = 1; sa = m_araddr; end
            if (rhs) ga = 0;
         end
         @(posedge clk); #1;
         m_arready = rnd ? 1'($urandom % 2) : 1'b1;
         if (!rst || rhs) m_rvalid = 0;
         else if (ga && !m_rvalid && (!rnd || $urandom % 3 == 0)) begin
            m_rvalid = 1; m_rdata = sa ^ RKEY; m_rresp = sa[7:6];
         end
      end
   endtask

   task automatic rand_writes(input int n, input int cnt);
      for (int k = 0; k < cnt; k++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         m_write(n, $urandom, $urandom, 4'($urandom), 3'($urandom),
                 $urandom_range(0, 2), $urandom_range(0, 2));
      end
   endtask

   task automatic rand_reads(input int n, input int cnt);
      for (int k = 0; k < cnt; k++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         m_read(n, $urandom, 3'($urandom), $urandom_range(0, 1));
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int  t;
      bit  got;
      rst = 0; rnd = 0; mon_en = 1; w_stall = 0;
      tb_awvalid = 2'b11; tb_wvalid = 2'b11; tb_arvalid = 2'b11;
      tb_bready = 2'b11; tb_rready = 2'b11;
      tb_awaddr = '1; tb_wdata = '1; tb_wstrb = '1; tb_awprot = '1;
      tb_araddr = '1; tb_arprot = '1;
      m_awready = 1; m_wready = 1; m_bvalid = 1; m_bresp = 2'b11;
      m_arready = 1; m_rvalid = 1; m_rresp = 2'b11; m_rdata = '1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_awvalid", {31'b0, m_awvalid}, 0);
      chk("rst_m_wvalid", {31'b0, m_wvalid}, 0);
      chk("rst_m_bready", {31'b0, m_bready}, 0);
      chk("rst_m_arvalid", {31'b0, m_arvalid}, 0);
      chk("rst_m_rready", {31'b0, m_rready}, 0);
      chk("rst_m_awaddr", m_awaddr, 0);
      chk("rst_m_wdata", m_wdata, 0);
      chk("rst_m_araddr", m_araddr, 0);
      chk("rst_s_readies", {22'b0, d_awready, d_wready, d_arready, d_bvalid, d_rvalid}, 0);
      chk("rst_s_resp", {28'b0, d_bresp[0], d_rresp[1]}, 0);
      chk("rst_s_rdata", d_rdata[0] | d_rdata[1], 0);

      tb_awvalid = 0; tb_wvalid = 0; tb_arvalid = 0; tb_bready = 0; tb_rready = 0;
      tb_awaddr = '0; tb_wdata = '0; tb_wstrb = '0; tb_awprot = '0;
      tb_araddr = '0; tb_arprot = '0;
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
      m_arready = 0; m_rvalid = 0; m_rresp = 0; m_rdata = '0;
      @(posedge clk); #1;
      rst = 1;
      fork
         slave_w();
         slave_r();
      join_none
      @(posedge clk); #1;

      // single write from s0
      m_write(0, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 0);
      // both masters read back to back four times each
      fork
         repeat (4) m_read(0, 32'h0000_0000, 3'd0, 0);
         repeat (4) m_read(1, 32'h0000_0010, 3'd1, 0);
      join
      // s1 presents W two cycles ahead of AW while the slave stalls W
      w_stall = 3;
      m_write(1, 32'h0000_2008, 32'h1234_5678, 4'h3, 3'd2, 2, 0);
      // independent paths at once
      fork
         m_write(0, 32'h0000_0100, 32'hCAFE_F00D, 4'hC, 3'd0, 0, 0);
         m_read(1, 32'h0000_00C4, 3'd0, 0);
      join
      // DECERR passed back to s1
      m_write(1, 32'h0000_0030, 32'h0BAD_0BAD, 4'hF, 3'd0, 0, 0);

      // randomized traffic from both masters on both paths
      rnd = 1;
      fork
         rand_writes(0, 25);
         rand_writes(1, 25);
         rand_reads(0, 25);
         rand_reads(1, 25);
      join
      rnd = 0;
      repeat (4) begin @(posedge clk); #1; end
      chk("w_queue_drained", wq.size(), 0);
      chk("r_queue_drained", rq.size(), 0);

      // asynchronous reset while the read path is returning data
      mon_en = 0;
      tb_araddr[0] = 32'h0000_0040; tb_arprot[0] = 3'd0; tb_arvalid[0] = 1; tb_rready[0] = 0;
      t = 0; got = 0;
      while (!got && t < TMO) begin
         @(negedge clk);
         got = d_arready[0];
         @(posedge clk); #1;
         t++;
      end
      if (!got) fail("rst_test_ar");
      tb_arvalid[0] = 0; tb_rready[0] = 1;
      #1;
      chk("pre_rst_s0_rvalid", {31'b0, d_rvalid[0]}, 1);
      chk("pre_rst_m_rready", {31'b0, m_rready}, 1);
      rst = 0;
      #1;
      chk("async_rst_m_rready", {31'b0, m_rready}, 0);
      chk("async_rst_s_rvalid", {30'b0, d_rvalid}, 0);
      tb_rready[0] = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1; mon_en = 1;
      @(posedge clk); #1;

      // first tie after reset goes to s0
      fork
         m_read(0, 32'h0000_0080, 3'd0, 0);
         m_read(1, 32'h0000_00C0, 3'd0, 0);
      join
      fork
         m_write(0, 32'h0000_0200, 32'h0000_0001, 4'h1, 3'd0, 0, 0);
         m_write(1, 32'h0000_0210, 32'h0000_0002, 4'h2, 3'd0, 0, 0);
      join
      repeat (4) begin @(posedge clk); #1; end
      chk("w_queue_drained_end", wq.size(), 0);
      chk("r_queue_drained_end", rq.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/axil_arbiter_2x1.md
Name: axil_arbiter_2x1

Overview:
- Two-master to one-slave AXI4-Lite arbiter that shares the crossbar's single slave port between the core (via its aligner) and a second bus master, such as a boot-loader or DMA engine.
- Write and read paths are arbitrated independently, each with round-robin fairness.
- One outstanding transaction per path. Channels are passed through combinationally once a grant is held.

Parameters:
DATA_WIDTH, 32, data bus width in bits
ADDR_WIDTH, 32, address width in bits
STRB_WIDTH, DATA_WIDTH/8, write strobe width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
sN_awaddr, sN_awprot, sN_awvalid (N=0,1)  in  ADDR_WIDTH,3,1  master N write-address channel
sN_awready  out  1  master N write-address ready
sN_wdata, sN_wstrb, sN_wvalid  in  DATA_WIDTH,STRB_WIDTH,1  master N write-data channel
sN_wready  out  1  master N write-data ready
sN_bresp, sN_bvalid  out  2,1  master N write response
sN_bready  in  1  master N response ready
sN_araddr, sN_arprot, sN_arvalid  in  ADDR_WIDTH,3,1  master N read-address channel
sN_arready  out  1  master N read-address ready
sN_rdata, sN_rresp, sN_rvalid  out  DATA_WIDTH,2,1  master N read data
sN_rready  in  1  master N read ready
m_awaddr, m_awprot, m_awvalid  out  ADDR_WIDTH,3,1  shared write-address channel
m_awready  in  1
m_wdata, m_wstrb, m_wvalid  out  DATA_WIDTH,STRB_WIDTH,1  shared write-data channel
m_wready  in  1
m_bresp, m_bvalid  in  2,1  shared write response
m_bready  out  1
m_araddr, m_arprot, m_arvalid  out  ADDR_WIDTH,3,1  shared read-address channel
m_arready  in  1
m_rdata, m_rresp, m_rvalid  in  DATA_WIDTH,2,1  shared read data
m_rready  out  1

Behaviour:
- Reset (rst=0, async): write FSM=W_IDLE, read FSM=R_IDLE. All valid/ready outputs go to 0 immediately. m_* addr/data/strb/prot and sN_* resp/rdata are 0. last_wgrant=last_rgrant=1, so master 0 wins the first tie.
- In-flight transactions are abandoned on reset. No recovery of slave-side state is attempted.

Write FSM:
- W_IDLE: a request is sN_awvalid=1.
  - One requester: grant it.
  - Both requesting: grant the master != last_wgrant.
  - Register wgrant, then go to W_XFER on the next edge. Arbitration latency is 1 cycle; no ready is asserted in W_IDLE.
- W_XFER: m_aw*/m_w* are muxed from the granted master.
  - m_awvalid = s_awvalid & ~aw_done; m_wvalid = s_wvalid & ~w_done.
  - Granted s_awready/s_wready = m_awready/m_wready gated by the same done flags.
  - aw_done and w_done are set on their respective handshakes, in either order or in the same cycle.
  - When both are done (including same cycle), go to W_RESP.
- W_RESP:
  - Granted sN_bvalid=m_bvalid, sN_bresp=m_bresp, m_bready=granted sN_bready.
  - On the B handshake: last_wgrant<=wgrant, clear the done flags, go to W_IDLE.
  - A new grant is possible on the cycle after return.
- Read FSM mirrors the write FSM (R_IDLE, R_ADDR, R_RESP):
  - Request is sN_arvalid.
  - R_ADDR forwards the AR channel until its handshake.
  - R_RESP forwards R until m_rvalid&m_rready, then updates last_rgrant.
- Non-granted master: all its ready/valid outputs stay 0. Its pending valid is held and served at the next arbitration.
- Read and write paths are fully independent. They may be granted to different masters simultaneously.
- Responses (bresp/rresp, including SLVERR/DECERR) pass through unmodified. No timeout.
- Requesters must hold valid until ready (AXI rule). Dropping valid after grant is unsupported.
- Fairness: under continuous contention, grants alternate 0,1,0,1 per path.

Test Plan:
- s0 write awaddr=0x10000004, wdata=0xDEADBEEF, wstrb=4'hF, slave awready/wready=1, bresp=0 -> m_awvalid rises 1 cycle after s0_awvalid; s0_bvalid with bresp=0; s1_* outputs stay 0 throughout.
- After reset, s0 and s1 both assert arvalid (0x00000000, 0x00000010), repeated 4 times -> m_araddr grant order s0,s1,s0,s1; each s_rdata matches its request.
- s1 asserts wvalid 2 cycles before awvalid, slave holds m_wready=0 for 3 cycles -> exactly one m_aw and one m_w handshake, single s1_bvalid, FSM back to W_IDLE.
- s0 write and s1 read issued in the same cycle -> both transactions complete concurrently with no added latency beyond 1-cycle grant each.
- rst driven low while the read FSM is in R_RESP -> m_rready and all sN_rvalid are 0 in the same cycle without a clock edge; after release, simultaneous requests grant s0 first.
- Slave returns m_bresp=2'b11 to s1 write -> s1_bresp=2'b11, s0_bvalid=0.
